// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter between NUM_REQ byte-stream
// requesters, with optional packet lock and a lock timeout.
module uart_tx_arbiter #(
    parameter int NUM_REQ      = 4,
    parameter int ID_W         = 2,
    parameter bit PKT_LOCK     = 1'b1,
    parameter int LOCK_TIMEOUT = 1024
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [8*NUM_REQ-1:0] req_data,
    input  logic [NUM_REQ-1:0]   req_last,
    output logic [NUM_REQ-1:0]   req_ready,
    output logic [7:0]           uart_tx_byte,
    output logic                 uart_transmit,
    input  logic                 uart_is_transmitting,
    output logic [ID_W-1:0]      grant_id,
    output logic                 busy,
    output logic                 lock_dropped
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int CNT_W = (LOCK_TIMEOUT > 0) ? $clog2(LOCK_TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((LOCK_TIMEOUT > 0) ? LOCK_TIMEOUT - 1 : 0);
    localparam logic [ID_W-1:0] LAST_ID = ID_W'(NUM_REQ - 1);
    localparam logic [NUM_REQ-1:0] ONE_HOT0 = NUM_REQ'(1);

    typedef enum logic [2:0] {IDLE, ACCEPT, START, SEND, HOLD} state_t;

    state_t             state;
    logic [ID_W-1:0]    rr_ptr;
    logic [CNT_W-1:0]   tmo_cnt;
    logic               last_q;

    logic [7:0]         req_bytes [NUM_REQ];
    logic [IDX_W-1:0]   grant_idx;
    logic [ID_W-1:0]    next_id;
    logic [NUM_REQ-1:0] rot_valid;
    logic               pick_found;
    logic [ID_W-1:0]    pick_id;
    int                 pick_sum;

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign req_bytes[g] = req_data[8*g +: 8];
    end

    assign grant_idx = IDX_W'(grant_id);
    assign next_id   = (grant_id == LAST_ID) ? '0 : grant_id + 1'b1;
    // Requests rotated so that bit 0 is the requester rr_ptr points at.
    assign rot_valid = NUM_REQ'({req_valid, req_valid} >> rr_ptr);

    // NOTE: every variable written here gets a default first, so no latch is inferred.
    always_comb begin
        pick_found = 1'b0;
        pick_id    = '0;
        pick_sum   = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (rot_valid[i] && !pick_found) begin
                pick_found = 1'b1;
                pick_sum   = int'(rr_ptr) + i;
                if (pick_sum >= NUM_REQ) pick_sum = pick_sum - NUM_REQ;
                pick_id    = ID_W'(pick_sum);
            end
        end
    end

    // NOTE: all state and registered outputs update with non-blocking assignments.
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            rr_ptr        <= '0;
            tmo_cnt       <= '0;
            last_q        <= 1'b0;
            req_ready     <= '0;
            uart_tx_byte  <= '0;
            uart_transmit <= 1'b0;
            grant_id      <= '0;
            busy          <= 1'b0;
            lock_dropped  <= 1'b0;
        end else begin
            req_ready    <= '0;
            lock_dropped <= 1'b0;
            case (state)
                IDLE: begin
                    if (pick_found) begin
                        grant_id  <= pick_id;
                        req_ready <= ONE_HOT0 << pick_id;
                        busy      <= 1'b1;
                        state     <= ACCEPT;
                    end
                end
                ACCEPT: begin
                    uart_tx_byte  <= req_bytes[grant_idx];
                    last_q        <= req_last[grant_idx];
                    uart_transmit <= 1'b1;
                    state         <= START;
                end
                START: begin
                    if (uart_is_transmitting) begin
                        uart_transmit <= 1'b0;
                        state         <= SEND;
                    end
                end
                SEND: begin
                    if (!uart_is_transmitting) begin
                        if (!PKT_LOCK || last_q) begin
                            rr_ptr <= next_id;
                            busy   <= 1'b0;
                            state  <= IDLE;
                        end else begin
                            tmo_cnt <= '0;
                            state   <= HOLD;
                        end
                    end
                end
                HOLD: begin
                    // Only the locked requester can continue the packet.
                    if (req_valid[grant_idx]) begin
                        req_ready <= ONE_HOT0 << grant_id;
                        state     <= ACCEPT;
                    end else if (LOCK_TIMEOUT != 0 && tmo_cnt == CNT_LAST) begin
                        lock_dropped <= 1'b1;
                        rr_ptr       <= next_id;
                        busy         <= 1'b0;
                        state        <= IDLE;
                    end else if (tmo_cnt != '1) begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: instance 0 uses packet lock with a 16-cycle
// timeout, instance 1 re-arbitrates after every byte.
module tb_uart_tx_arbiter;

    logic        clk;
    logic        reset;
    logic [3:0]  r_valid  [2];
    logic [31:0] r_data   [2];
    logic [3:0]  r_last   [2];
    logic [3:0]  r_ready  [2];
    logic [7:0]  tx_byte  [2];
    logic        transmit [2];
    logic        is_tx    [2];
    logic [1:0]  grant    [2];
    logic        busy     [2];
    logic        dropped  [2];

    logic [8:0]  q     [8][$];
    logic [7:0]  txlog [2][$];
    logic [3:0]  acc   [2];
    int          ready_cnt [2][4];
    int          tx_cnt    [2];
    int          fall_tick [2];
    int          tick_count;
    int          tx_len;
    int          errors;
    int          checks;

    uart_tx_arbiter #(.NUM_REQ(4), .ID_W(2), .PKT_LOCK(1'b1), .LOCK_TIMEOUT(16)) dut_lock (
        .clk                  (clk),
        .reset                (reset),
        .req_valid            (r_valid[0]),
        .req_data             (r_data[0]),
        .req_last             (r_last[0]),
        .req_ready            (r_ready[0]),
        .uart_tx_byte         (tx_byte[0]),
        .uart_transmit        (transmit[0]),
        .uart_is_transmitting (is_tx[0]),
        .grant_id             (grant[0]),
        .busy                 (busy[0]),
        .lock_dropped         (dropped[0])
    );

    uart_tx_arbiter #(.NUM_REQ(4), .ID_W(2), .PKT_LOCK(1'b0), .LOCK_TIMEOUT(1024)) dut_nolock (
        .clk                  (clk),
        .reset                (reset),
        .req_valid            (r_valid[1]),
        .req_data             (r_data[1]),
        .req_last             (r_last[1]),
        .req_ready            (r_ready[1]),
        .uart_tx_byte         (tx_byte[1]),
        .uart_transmit        (transmit[1]),
        .uart_is_transmitting (is_tx[1]),
        .grant_id             (grant[1]),
        .busy                 (busy[1]),
        .lock_dropped         (dropped[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One cycle: requester drivers pop accepted bytes, UART models react to transmit.
    task automatic tick();
        logic [8:0] head;
        @(negedge clk);
        tick_count++;
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < 4; i++) begin
                if (acc[d][i] && q[d*4+i].size() > 0) void'(q[d*4+i].pop_front());
                if (r_ready[d][i]) ready_cnt[d][i]++;
            end
            acc[d] = reset ? 4'b0 : r_ready[d];
            for (int i = 0; i < 4; i++) begin
                if (q[d*4+i].size() > 0) begin
                    head = q[d*4+i][0];
                    r_valid[d][i]      = 1'b1;
                    r_data[d][8*i +: 8] = head[7:0];
                    r_last[d][i]       = head[8];
                end else begin
                    r_valid[d][i] = 1'b0;
                end
            end
            if (is_tx[d]) begin
                if (tx_cnt[d] <= 1) begin
                    is_tx[d]     = 1'b0;
                    fall_tick[d] = tick_count;
                end else begin
                    tx_cnt[d]--;
                end
            end else if (transmit[d]) begin
                txlog[d].push_back(tx_byte[d]);
                is_tx[d]  = 1'b1;
                tx_cnt[d] = tx_len;
            end
        end
    endtask

    task automatic push(input int d, input int i, input bit last, input logic [7:0] data);
        q[d*4+i].push_back({last, data});
    endtask

    task automatic clear_bench();
        for (int d = 0; d < 2; d++) begin
            txlog[d].delete();
            acc[d]    = 4'b0;
            is_tx[d]  = 1'b0;
            tx_cnt[d] = 0;
            for (int i = 0; i < 4; i++) begin
                q[d*4+i].delete();
                ready_cnt[d][i] = 0;
            end
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        clear_bench();
        tick();
        tick();
        reset = 1'b0;
        tick();
    endtask

    task automatic wait_idle(input int d, input int bound, input string name);
        bit done = 1'b0;
        for (int n = 0; n < bound && !done; n++) begin
            tick();
            done = (r_valid[d] == 4'b0) && !busy[d] && !is_tx[d];
        end
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL %s: no return to idle within %0d cycles", name, bound);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        clear_bench();
        tick();
        tick();
        checks++;
        if (r_ready[0] !== 4'b0) begin errors++; $display("FAIL reset_ready: got %b want 0000", r_ready[0]); end
        checks++;
        if (transmit[0] !== 1'b0) begin errors++; $display("FAIL reset_transmit: got %b want 0", transmit[0]); end
        checks++;
        if (tx_byte[0] !== 8'h00) begin errors++; $display("FAIL reset_tx_byte: got %h want 00", tx_byte[0]); end
        checks++;
        if (grant[0] !== 2'd0) begin errors++; $display("FAIL reset_grant: got %0d want 0", grant[0]); end
        checks++;
        if (busy[0] !== 1'b0 || busy[1] !== 1'b0) begin
            errors++; $display("FAIL reset_busy: got %b%b want 00", busy[0], busy[1]);
        end
        checks++;
        if (dropped[0] !== 1'b0) begin errors++; $display("FAIL reset_lock_dropped: got %b want 0", dropped[0]); end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_single();
        tx_len = 100;
        push(0, 0, 1'b1, 8'h78);
        tick();
        tick();
        checks++;
        if (r_ready[0] !== 4'b0001) begin errors++; $display("FAIL single_accept_ready: got %b want 0001", r_ready[0]); end
        tick();
        checks++;
        if (transmit[0] !== 1'b1) begin errors++; $display("FAIL single_latency: transmit got %b want 1 two cycles after valid", transmit[0]); end
        checks++;
        if (tx_byte[0] !== 8'h78) begin errors++; $display("FAIL single_tx_byte: got %h want 78", tx_byte[0]); end
        checks++;
        if (r_ready[0] !== 4'b0000 || busy[0] !== 1'b1) begin
            errors++; $display("FAIL single_start: ready=%b busy=%b want 0000/1", r_ready[0], busy[0]);
        end
        tick();
        checks++;
        if (transmit[0] !== 1'b0) begin errors++; $display("FAIL single_transmit_drop: got %b want 0", transmit[0]); end
        wait_idle(0, 300, "single_idle");
        checks++;
        if (ready_cnt[0][0] !== 1) begin errors++; $display("FAIL single_ready_count: got %0d want 1", ready_cnt[0][0]); end
        checks++;
        if (txlog[0].size() !== 1 || txlog[0][0] !== 8'h78) begin
            errors++; $display("FAIL single_log: got %0d bytes want 1 byte 78", txlog[0].size());
        end
        checks++;
        if (busy[0] !== 1'b0) begin errors++; $display("FAIL single_busy_end: got %b want 0", busy[0]); end
    endtask

    task automatic test_round_robin();
        logic [7:0] exp_rr [8];
        exp_rr = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hB0, 8'hB1, 8'hB2, 8'hB3};
        do_reset();
        tx_len = 3;
        for (int i = 0; i < 4; i++) push(0, i, 1'b1, 8'hA0 + 8'(i));
        for (int i = 0; i < 4; i++) push(0, i, 1'b1, 8'hB0 + 8'(i));
        wait_idle(0, 500, "rr_idle");
        checks++;
        if (txlog[0].size() !== 8) begin errors++; $display("FAIL rr_count: got %0d bytes want 8", txlog[0].size()); end
        for (int i = 0; i < 8 && i < txlog[0].size(); i++) begin
            checks++;
            if (txlog[0][i] !== exp_rr[i]) begin
                errors++; $display("FAIL rr_order[%0d]: got %h want %h", i, txlog[0][i], exp_rr[i]);
            end
        end
    endtask

    task automatic test_pkt_lock();
        logic [7:0] exp_pk [4];
        exp_pk = '{8'h10, 8'h11, 8'h12, 8'h20};
        txlog[0].delete();
        push(0, 1, 1'b0, 8'h10);
        push(0, 1, 1'b0, 8'h11);
        push(0, 1, 1'b1, 8'h12);
        push(0, 2, 1'b1, 8'h20);
        wait_idle(0, 300, "lock_idle");
        checks++;
        if (txlog[0].size() !== 4) begin errors++; $display("FAIL lock_count: got %0d bytes want 4", txlog[0].size()); end
        for (int i = 0; i < 4 && i < txlog[0].size(); i++) begin
            checks++;
            if (txlog[0][i] !== exp_pk[i]) begin
                errors++; $display("FAIL lock_order[%0d]: got %h want %h", i, txlog[0][i], exp_pk[i]);
            end
        end
        checks++;
        if (grant[0] !== 2'd2) begin errors++; $display("FAIL lock_last_grant: got %0d want 2", grant[0]); end
    endtask

    task automatic test_lock_timeout();
        int  drop_tick;
        bit  seen;
        txlog[0].delete();
        drop_tick = 0;
        seen      = 1'b0;
        push(0, 3, 1'b0, 8'h30);
        push(0, 0, 1'b1, 8'h40);
        for (int n = 0; n < 200 && !seen; n++) begin
            tick();
            if (dropped[0]) begin
                seen      = 1'b1;
                drop_tick = tick_count;
            end
        end
        checks++;
        if (!seen) begin
            errors++; $display("FAIL timeout_pulse: lock_dropped not seen within 200 cycles");
        end else begin
            checks++;
            if (drop_tick - (fall_tick[0] + 1) !== 16) begin
                errors++; $display("FAIL timeout_delay: got %0d cycles in HOLD want 16", drop_tick - (fall_tick[0] + 1));
            end
            checks++;
            if (txlog[0].size() !== 1 || busy[0] !== 1'b0) begin
                errors++; $display("FAIL timeout_state: bytes=%0d busy=%b want 1/0", txlog[0].size(), busy[0]);
            end
            tick();
            checks++;
            if (dropped[0] !== 1'b0) begin errors++; $display("FAIL timeout_pulse_width: got %b want 0", dropped[0]); end
        end
        wait_idle(0, 300, "timeout_idle");
        checks++;
        if (txlog[0].size() !== 2 || txlog[0][0] !== 8'h30 || txlog[0][1] !== 8'h40) begin
            errors++; $display("FAIL timeout_order: got %0d bytes want 30 then 40", txlog[0].size());
        end
        checks++;
        if (grant[0] !== 2'd0) begin errors++; $display("FAIL timeout_next_grant: got %0d want 0", grant[0]); end
    endtask

    task automatic test_reset_mid();
        bit seen = 1'b0;
        push(0, 2, 1'b1, 8'h55);
        for (int n = 0; n < 20 && !seen; n++) begin
            tick();
            seen = transmit[0];
        end
        checks++;
        if (!seen || grant[0] !== 2'd2) begin
            errors++; $display("FAIL midreset_start: transmit=%b grant=%0d want 1/2", seen, grant[0]);
        end
        reset = 1'b1;
        clear_bench();
        tick();
        checks++;
        if (transmit[0] !== 1'b0 || tx_byte[0] !== 8'h00 || grant[0] !== 2'd0 || busy[0] !== 1'b0 || r_ready[0] !== 4'b0) begin
            errors++;
            $display("FAIL midreset_outputs: tx=%b byte=%h grant=%0d busy=%b ready=%b want all 0",
                     transmit[0], tx_byte[0], grant[0], busy[0], r_ready[0]);
        end
        tick();
        checks++;
        if (r_ready[0] !== 4'b0 || transmit[0] !== 1'b0) begin
            errors++; $display("FAIL midreset_hold: ready=%b tx=%b want 0000/0", r_ready[0], transmit[0]);
        end
        reset = 1'b0;
        tx_len = 3;
        push(0, 1, 1'b1, 8'h67);
        push(0, 0, 1'b1, 8'h66);
        wait_idle(0, 300, "midreset_idle");
        checks++;
        if (txlog[0].size() !== 2 || txlog[0][0] !== 8'h66 || txlog[0][1] !== 8'h67) begin
            errors++; $display("FAIL midreset_rr_order: got %0d bytes want 66 then 67", txlog[0].size());
        end
    endtask

    task automatic test_no_lock();
        logic [7:0] exp_nl [3];
        exp_nl = '{8'h70, 8'h80, 8'h71};
        txlog[1].delete();
        tx_len = 3;
        push(1, 0, 1'b0, 8'h70);
        push(1, 0, 1'b1, 8'h71);
        push(1, 1, 1'b1, 8'h80);
        wait_idle(1, 300, "nolock_idle");
        checks++;
        if (txlog[1].size() !== 3) begin errors++; $display("FAIL nolock_count: got %0d bytes want 3", txlog[1].size()); end
        for (int i = 0; i < 3 && i < txlog[1].size(); i++) begin
            checks++;
            if (txlog[1][i] !== exp_nl[i]) begin
                errors++; $display("FAIL nolock_order[%0d]: got %h want %h", i, txlog[1][i], exp_nl[i]);
            end
        end
    endtask

    initial begin
        errors     = 0;
        checks     = 0;
        tick_count = 0;
        tx_len     = 3;
        reset      = 1'b1;
        for (int d = 0; d < 2; d++) begin
            r_valid[d]   = 4'b0;
            r_data[d]    = 32'h0;
            r_last[d]    = 4'b0;
            fall_tick[d] = 0;
        end
        clear_bench();
        test_reset();
        test_single();
        test_round_robin();
        test_pkt_lock();
        test_lock_timeout();
        test_reset_mid();
        test_no_lock();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
